// File: rtl/div_seq_ctrl_if.sv
// rtl/div_seq_ctrl_if.sv - EX-stage divide request/response bundle
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle restoring DIV/DIVU sequencer with pipeline stall request
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  div_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 sgn1_q, sgn1_d;
  logic                 sgn2_q, sgn2_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     rem_next;
  logic [WIDTH-1:0]     quo_next;
  logic                 op1_neg;
  logic                 op2_neg;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    result_d = result_q;
    ready_d  = ready_q;

    // Partial remainder stays below the divisor, so a WIDTH+1-bit difference
    // has its MSB set exactly when the trial subtraction goes negative.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    op1_neg  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    op2_neg  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          sgn1_d  = op1_neg;
          sgn2_d  = op2_neg;
          quo_d   = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
          dvs_d   = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (bus.opdata2_i == '0) ? S_BYZERO : S_RUN;
        end
      end
      S_BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_RUN: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CNT_LAST) begin
          state_d  = S_DONE;
          ready_d  = 1'b1;
          result_d = {(sgn1_q ? -rem_next : rem_next),
                      ((sgn1_q ^ sgn2_q) ? -quo_next : quo_next)};
        end
      end
      default: begin
        if (!bus.start_i) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end
      end
    endcase

    // Flush/exception cancels any divide in flight; result_o keeps its last value.
    if (bus.annul_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      ready_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready_q;

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle divide sequencer for the EX stage of the MIPS32 pipeline.
- Accepts DIV/DIVU operands from EX and runs a 32-iteration restoring division FSM.
- Raises a stall request to the pipeline controller while the divide is in progress.
- Returns the 64-bit {remainder, quotient} result. EX forwards it as hi/lo with whilo set, and it then travels down the EX/MEM register to HI/LO.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits, iteration count equals WIDTH.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
opdata1_i  input  WIDTH  dividend (rs)
opdata2_i  input  WIDTH  divisor (rt)
start_i  input  1  divide request from EX; held high by EX while stalled
annul_i  input  1  cancel request (flush / exception); highest priority after rst
result_o  output  2*WIDTH  [63:32] remainder -> HI, [31:0] quotient -> LO
ready_o  output  1  result valid
stallreq_o  output  1  stall request to pipeline control

Behaviour:
- Interface rule: reset rst, synchronous, active-high; clock clk.
- Reset value of every output and register:
  - state = IDLE, counter = 0, result_o = 0, ready_o = 0.
  - stallreq_o is then 0, provided start_i is 0.
- FSM states are IDLE, BYZERO, RUN and DONE. All transitions happen at posedge clk.
- IDLE:
  - If start_i=1 and annul_i=0, latch the operands.
  - Signed mode: store |opdata1| and |opdata2| and record both sign bits.
  - Unsigned mode: store the raw values with signs treated as 0.
  - If opdata2_i==0, go to BYZERO; otherwise go to RUN with counter=0 and partial remainder=0.
  - If annul_i=1, start is ignored.
- BYZERO: next cycle go to DONE with result_o = 0. Divide-by-zero result is defined as 0.
- RUN, one quotient bit per cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor, using a WIDTH+1-bit subtract.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - Increment counter. When counter reaches WIDTH, go to DONE.
  - On the DONE transition, apply sign fixup:
    - Quotient is negated when the two signs differ.
    - Remainder takes the sign of the dividend.
  - Load result_o = {rem, quot}.
- DONE:
  - ready_o = 1 and result_o is held stable.
  - Stay in DONE while start_i=1. Go to IDLE on the first cycle start_i=0; ready_o drops in that same transition.
- annul_i=1 in BYZERO, RUN or DONE:
  - Next state is IDLE, ready_o = 0, counter = 0.
  - result_o is not updated.
- stallreq_o = start_i & ~annul_i & ~ready_o (combinational). It therefore deasserts in the cycle ready_o rises, which lets EX capture the result.
- Latency, with start accepted at edge T:
  - Normal divide: 32 RUN cycles, ready_o high from T+33.
  - Divide-by-zero: ready_o high from T+2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (natural wrap, no trap).
- Operand changes on the inputs after acceptance are ignored until the FSM returns to IDLE.
- start_i asserted again in the same cycle the FSM enters IDLE: accepted on the following edge, as normal IDLE behaviour.

Test Plan:
1. DIVU 7/2, start held high:
   - stallreq_o=1 for 33 cycles.
   - ready_o=1 at T+33 with result_o=0x00000001_00000003, stallreq_o=0.
   - Drop start: IDLE, ready_o=0.
2. DIV -7/2 (0xFFFFFFF9 / 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD at T+33.
   - Also DIV 7/-2: result_o = 0x00000001_FFFFFFFD.
3. DIVU 5/0: BYZERO path, ready_o=1 at T+2, result_o=0.
4. DIV 0x80000000/0xFFFFFFFF: result_o = 0x00000000_80000000, no hang.
5. Start DIVU 100/7, assert annul_i for 1 cycle at RUN iteration 10:
   - FSM returns to IDLE, ready_o never rises, stallreq_o=0 during annul.
   - Restart with 100/7 gives 0x00000002_0000000E at T'+33.
6. Assert rst at RUN iteration 20:
   - Next cycle state IDLE, ready_o=0, result_o=0.
   - Subsequent DIVU 0xFFFFFFFF/1 gives 0x00000000_FFFFFFFF.
